mem_cmd_queue: RTL and testbench

Command front-end sitting directly upstream of the 4×8 memory DUT. Buffers write/read commands from a valid/ready source in a small FIFO and issues them to the memory's `address`/`write_en`/`read_en`/`data_wr` port, one per cycle. Captures `data_rd` and returns it through a single-entry response slot with backpressure. It also gives the memory bench a queued, flow-controlled stimulus path.

---
 rtl/mem_cmd_queue.sv | 133 +++++++++++++
 tb/tb_mem_cmd_queue.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_cmd_queue.sv
// Command FIFO front-end for the 4x8 memory: queues read/write commands, issues one per cycle
// to the memory port, and returns read data through a single-entry response slot.
module mem_cmd_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int DW    = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_write,
    input  logic [AW-1:0]              cmd_addr,
    input  logic [DW-1:0]              cmd_wdata,
    output logic [AW-1:0]              address,
    output logic                       write_en,
    output logic                       read_en,
    output logic [DW-1:0]              data_wr,
    input  logic [DW-1:0]              data_rd,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DW-1:0]              rsp_data,
    output logic [AW-1:0]              rsp_addr,
    output logic [$clog2(DEPTH)+1-1:0] level,
    output logic                       idle
);

    localparam int PW = $clog2(DEPTH) + 1;
    localparam int EW = AW + DW + 1;

    logic [EW-1:0] fifo_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] level_q, level_d;
    logic          rd_inflight_q, rd_inflight_d;
    logic [AW-1:0] inflight_addr_q, inflight_addr_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;
    logic [AW-1:0] rsp_addr_q, rsp_addr_d;

    logic          full, empty, push, pop;
    logic          issue_wr, issue_rd;
    logic [EW-1:0] head;
    logic          head_write;
    logic [AW-1:0] head_addr;
    logic [DW-1:0] head_data;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);

    assign head       = fifo_q[rd_ptr_q[PW-2:0]];
    assign head_write = head[EW-1];
    assign head_addr  = head[EW-2:DW];
    assign head_data  = head[DW-1:0];

    // A read may only issue when the response slot is free by the time its data lands.
    assign issue_wr = !empty && head_write;
    assign issue_rd = !empty && !head_write && !rd_inflight_q && (!rsp_valid_q || rsp_ready);

    assign push = cmd_valid && !full;
    assign pop  = issue_wr || issue_rd;

    always_comb begin
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        level_d         = level_q;
        rd_inflight_d   = issue_rd;
        inflight_addr_d = issue_rd ? head_addr : inflight_addr_q;
        rsp_valid_d     = rsp_valid_q;
        rsp_data_d      = rsp_data_q;
        rsp_addr_d      = rsp_addr_q;

        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);

        case ({push, pop})
            2'b10:   level_d = level_q + PW'(1);
            2'b01:   level_d = level_q - PW'(1);
            default: level_d = level_q;
        endcase

        if (rd_inflight_q) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = data_rd;
            rsp_addr_d  = inflight_addr_q;
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            level_q         <= '0;
            rd_inflight_q   <= 1'b0;
            inflight_addr_q <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_data_q      <= '0;
            rsp_addr_q      <= '0;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            level_q         <= level_d;
            rd_inflight_q   <= rd_inflight_d;
            inflight_addr_q <= inflight_addr_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_data_q      <= rsp_data_d;
            rsp_addr_q      <= rsp_addr_d;
        end
    end

    // Storage carries no reset; only the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q[PW-2:0]] <= {cmd_write, cmd_addr, cmd_wdata};
    end

    assign address   = pop ? head_addr : '0;
    assign write_en  = issue_wr;
    assign read_en   = issue_rd;
    assign data_wr   = issue_wr ? head_data : '0;

    assign cmd_ready = !full;
    assign level     = level_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_addr  = rsp_addr_q;
    assign idle      = empty && !rd_inflight_q && !rsp_valid_q;

endmodule

// File: tb/tb_mem_cmd_queue.sv
// Directed bench for mem_cmd_queue with a behavioural 4x8 memory attached to its memory port.
module tb_mem_cmd_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int DW    = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [AW-1:0] address;
    logic          write_en, read_en;
    logic [DW-1:0] data_wr;
    logic [DW-1:0] data_rd;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] rsp_addr;
    logic [LW-1:0] level;
    logic          idle;

    int n_vec = 0;
    int n_bad = 0;

    logic [DW-1:0] mem [4];

    mem_cmd_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .address(address), .write_en(write_en), .read_en(read_en),
        .data_wr(data_wr), .data_rd(data_rd),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_addr(rsp_addr), .level(level), .idle(idle)
    );

    always #5 clk = ~clk;

    // Memory: synchronous write, registered read data one cycle after read_en.
    always @(posedge clk) begin
        if (write_en) mem[address] <= data_wr;
        if (read_en)  data_rd <= mem[address];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cmd_valid = v;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
    endtask

    logic [DW-1:0] b2b_data [4];

    initial begin
        for (int i = 0; i < 4; i++) mem[i] = 8'h10 + 8'(i);
        data_rd   = '0;
        reset     = 1'b0;
        rsp_ready = 1'b0;
        drive(0, 0, 0, 0);

        // Reset state
        cyc(); cyc(); #1;
        check_eq("rst_cmd_ready", cmd_ready, 1);
        check_eq("rst_level", level, 0);
        check_eq("rst_idle", idle, 1);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_strobes", {write_en, read_en}, 0);
        check_eq("rst_addr_data", {address, data_wr}, 0);
        check_eq("rst_rsp_payload", {rsp_addr, rsp_data}, 0);
        cyc(); reset = 1'b1;

        // Write then read to the same address
        cyc(); drive(1, 1, 2, 8'hA5); rsp_ready = 1'b1; #1;
        check_eq("wr_rd_accept", cmd_ready, 1);
        cyc(); drive(1, 0, 2, 0); #1;
        check_eq("wr_rd_wen", {write_en, read_en}, 2'b10);
        check_eq("wr_rd_waddr", address, 2);
        check_eq("wr_rd_wdata", data_wr, 8'hA5);
        check_eq("wr_rd_level1", level, 1);
        cyc(); drive(0, 0, 0, 0); #1;
        check_eq("wr_rd_ren", {write_en, read_en}, 2'b01);
        check_eq("wr_rd_raddr", address, 2);
        check_eq("wr_rd_rdata0", data_wr, 0);
        cyc(); #1;
        check_eq("wr_rd_inflight_strobe", read_en, 0);
        check_eq("wr_rd_inflight_rv", rsp_valid, 0);
        check_eq("wr_rd_inflight_idle", idle, 0);
        cyc(); #1;
        check_eq("wr_rd_rsp_valid", rsp_valid, 1);
        check_eq("wr_rd_rsp_data", rsp_data, 8'hA5);
        check_eq("wr_rd_rsp_addr", rsp_addr, 2);
        cyc(); #1;
        check_eq("wr_rd_rsp_clear", rsp_valid, 0);
        check_eq("wr_rd_idle", idle, 1);

        // Backpressure and full
        rsp_ready = 1'b0;
        cyc(); drive(1, 0, 1, 0); #1;
        check_eq("bp_level0", level, 0);
        cyc(); drive(1, 0, 3, 0); #1;
        check_eq("bp_rd1_ren", read_en, 1);
        check_eq("bp_rd1_addr", address, 1);
        cyc(); drive(1, 1, 0, 8'hB0); #1;
        check_eq("bp_rd2_blocked_inflight", read_en, 0);
        check_eq("bp_level_a2", level, 1);
        cyc(); drive(1, 1, 1, 8'hB1); #1;
        check_eq("bp_rsp1_valid", rsp_valid, 1);
        check_eq("bp_rsp1_data", rsp_data, 8'h11);
        check_eq("bp_rsp1_addr", rsp_addr, 1);
        check_eq("bp_rd2_blocked_rsp", read_en, 0);
        check_eq("bp_level_a3", level, 2);
        cyc(); drive(1, 1, 2, 8'hB2); #1;
        check_eq("bp_level_a4", level, 3);
        check_eq("bp_ready_a4", cmd_ready, 1);
        cyc(); drive(1, 1, 3, 8'hB3); #1;
        check_eq("bp_full_level", level, 4);
        check_eq("bp_full_ready", cmd_ready, 0);
        check_eq("bp_full_strobes", {write_en, read_en}, 0);
        check_eq("bp_rsp1_hold", {rsp_valid, rsp_addr, rsp_data}, {1'b1, 2'd1, 8'h11});
        cyc(); rsp_ready = 1'b1; #1;
        check_eq("bp_rd2_ren", read_en, 1);
        check_eq("bp_rd2_addr", address, 3);
        check_eq("bp_rd2_level", level, 4);
        check_eq("bp_rd2_ready", cmd_ready, 0);
        cyc(); #1;
        check_eq("bp_w0_ready", cmd_ready, 1);
        check_eq("bp_w0", {write_en, address, data_wr}, {1'b1, 2'd0, 8'hB0});
        check_eq("bp_w0_rv", rsp_valid, 0);
        check_eq("bp_w0_level", level, 3);
        cyc(); drive(0, 0, 0, 0); #1;
        check_eq("bp_rsp2", {rsp_valid, rsp_addr, rsp_data}, {1'b1, 2'd3, 8'h13});
        check_eq("bp_w1", {write_en, address, data_wr}, {1'b1, 2'd1, 8'hB1});
        check_eq("bp_w1_level", level, 3);
        cyc(); #1;
        check_eq("bp_w2", {write_en, address, data_wr}, {1'b1, 2'd2, 8'hB2});
        check_eq("bp_w2_level", level, 2);
        check_eq("bp_w2_rv", rsp_valid, 0);
        cyc(); #1;
        check_eq("bp_w3", {write_en, address, data_wr}, {1'b1, 2'd3, 8'hB3});
        check_eq("bp_w3_level", level, 1);
        cyc(); #1;
        check_eq("bp_done_wen", write_en, 0);
        check_eq("bp_done_idle", idle, 1);
        check_eq("bp_done_level", level, 0);

        // Streaming writes: push and pop on the same edge
        for (int i = 0; i < 5; i++) begin
            cyc(); drive(1, 1, AW'(i % 4), 8'hC0 + 8'(i)); #1;
            if (i == 0) begin
                check_eq("st_first_wen", write_en, 0);
            end else begin
                check_eq("st_wen", write_en, 1);
                check_eq("st_wdata", data_wr, 8'hC0 + 8'(i - 1));
                check_eq("st_waddr", address, 32'((i - 1) % 4));
                check_eq("st_level", level, 1);
            end
        end
        cyc(); drive(0, 0, 0, 0); #1;
        check_eq("st_last", {write_en, address, data_wr}, {1'b1, 2'd0, 8'hC4});
        check_eq("st_last_level", level, 1);
        cyc(); #1;
        check_eq("st_idle", idle, 1);
        check_eq("st_level0", level, 0);

        // Back-to-back reads of addresses 0..3
        b2b_data[0] = 8'hC4; b2b_data[1] = 8'hC1; b2b_data[2] = 8'hC2; b2b_data[3] = 8'hC3;
        for (int k = 0; k < 11; k++) begin
            cyc();
            if (k < 4) drive(1, 0, AW'(k), 0);
            else       drive(0, 0, 0, 0);
            #1;
            if (k >= 1 && k <= 8) check_eq("b2b_ren", read_en, ((k % 2) == 1) ? 1 : 0);
            if ((k % 2) == 1 && k <= 7) check_eq("b2b_raddr", address, 32'((k - 1) / 2));
            if (k >= 2) check_eq("b2b_rv", rsp_valid, ((k % 2) == 1) ? 1 : 0);
            if ((k % 2) == 1 && k >= 3) begin
                check_eq("b2b_rdata", rsp_data, b2b_data[(k - 3) / 2]);
                check_eq("b2b_raddr_rsp", rsp_addr, 32'((k - 3) / 2));
            end
        end
        check_eq("b2b_idle", idle, 1);
        check_eq("b2b_level", level, 0);

        // Reset during a read in flight
        cyc(); drive(1, 0, 1, 0); #1;
        cyc(); drive(0, 0, 0, 0); #1;
        check_eq("rr_ren", read_en, 1);
        cyc(); reset = 1'b0; #1;
        check_eq("rr_async_idle", idle, 1);
        check_eq("rr_async_level", level, 0);
        check_eq("rr_async_rv", rsp_valid, 0);
        cyc(); reset = 1'b1; #1;
        check_eq("rr_rel_rv", rsp_valid, 0);
        cyc(); #1;
        check_eq("rr_post_rv", rsp_valid, 0);
        check_eq("rr_post_idle", idle, 1);
        check_eq("rr_post_level", level, 0);
        check_eq("rr_post_ready", cmd_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
